// File: rtl/spi_flash_rd_pkg.sv
// Shared definitions for the SPI flash reader.
// - Register offsets of the spi register block (SPI_CR, SPI_SR, SPI_DR, SPI_DFR, SPI_CS_V).
// - spi_sr_v: bit layout of the spi status register (spi_rd[7:0] when addressing SPI_SR).
// - state_e: reader FSM states; FLASH_CMD_READ and CHUNK constants.
// - bus_op_t plus helpers that build one registered bus access.
package spi_flash_rd_pkg;

  localparam logic [4:0] SPI_CR   = 5'h00;
  localparam logic [4:0] SPI_SR   = 5'h04;
  localparam logic [4:0] SPI_DR   = 5'h08;
  localparam logic [4:0] SPI_DFR  = 5'h0c;
  localparam logic [4:0] SPI_CS_V = 5'h10;

  typedef struct packed {
    logic [2:0] rsvd;
    logic       busy;
    logic       rx_fifo_full;
    logic       rx_fifo_emp;
    logic       tx_fifo_full;
    logic       tx_fifo_emp;
  } spi_sr_v;

  localparam logic [7:0]  FLASH_CMD_READ = 8'h03;
  localparam int unsigned CHUNK          = 8;

  typedef enum logic [3:0] {
    StIdle, StCfg, StCmd, StWcmd, StDcmd, StPush, StWdat, StPop, StCsoff, StFin
  } state_e;

  typedef struct packed {
    logic        we;
    logic        re;
    logic [4:0]  addr;
    logic [31:0] wd;
  } bus_op_t;

  function automatic bus_op_t bus_wr(input logic [4:0] addr, input logic [31:0] data);
    bus_op_t op;
    op.we   = 1'b1;
    op.re   = 1'b0;
    op.addr = addr;
    op.wd   = data;
    return op;
  endfunction

  function automatic bus_op_t bus_rd(input logic [4:0] addr, input logic re);
    bus_op_t op;
    op.we   = 1'b0;
    op.re   = re;
    op.addr = addr;
    op.wd   = '0;
    return op;
  endfunction

endpackage

// File: rtl/spi_flash_rd_if.sv
// Simple register bus between the flash reader (master) and the spi block (slave).
// - spi_addr/spi_re/spi_we/spi_wd: access driven by the master.
// - spi_rd: read data, combinational from spi_addr on the slave side.
interface spi_flash_rd_if;
  logic [4:0]  spi_addr;
  logic        spi_re;
  logic        spi_we;
  logic [31:0] spi_wd;
  logic [31:0] spi_rd;

  modport master (output spi_addr, spi_re, spi_we, spi_wd, input spi_rd);
  modport slave  (input spi_addr, spi_re, spi_we, spi_wd, output spi_rd);
endinterface

// File: rtl/spi_flash_rd.sv
// SPI flash reader: on start, reads len bytes from a 25-series flash (READ 0x03, 24-bit
// address) through the spi register block and streams them out on a valid/ready port.
// Ports:
// - clk, rst: clock, asynchronous active-high reset.
// - start, flash_addr, len, dfv: request; captured on start while idle.
// - busy, done: busy from the cycle after start until done; done is a one-cycle pulse.
// - out_data, out_valid, out_ready: received byte stream.
// - bus: master side of the spi register bus.
module spi_flash_rd
  import spi_flash_rd_pkg::*;
#(
  parameter int unsigned cs_w   = 8,
  parameter int unsigned cs_idx = 0,
  parameter int unsigned len_w  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [23:0]      flash_addr,
  input  logic [len_w-1:0] len,
  input  logic [7:0]       dfv,
  output logic             busy,
  output logic             done,
  output logic [7:0]       out_data,
  output logic             out_valid,
  input  logic             out_ready,
  spi_flash_rd_if.master   bus
);

  localparam logic [32:0] CsAllW = (33'd1 << cs_w) - 33'd1;
  localparam logic [31:0] CsAll  = CsAllW[31:0];
  localparam logic [31:0] CsSel  = CsAll & ~(32'd1 << cs_idx);

  state_e           st;
  logic [3:0]       step;
  logic [3:0]       chunk;
  logic [len_w-1:0] rem;
  logic [23:0]      addr_q;
  bus_op_t          op;
  spi_sr_v          sr;
  logic [3:0]       rem_chunk;
  logic             unused_rd;

  assign sr        = spi_sr_v'(bus.spi_rd[7:0]);
  assign unused_rd = ^{bus.spi_rd[31:8], sr.rsvd, sr.busy, sr.rx_fifo_full, sr.rx_fifo_emp,
                       sr.tx_fifo_full};
  assign rem_chunk = (rem > len_w'(CHUNK)) ? 4'(CHUNK) : rem[3:0];

  // The pop strobe follows out_ready combinationally so a byte leaves the rx FIFO in the
  // same cycle it is accepted.
  assign bus.spi_addr = op.addr;
  assign bus.spi_we   = op.we;
  assign bus.spi_wd   = op.wd;
  assign bus.spi_re   = op.re | (out_valid & out_ready);
  assign out_data     = bus.spi_rd[7:0];

  // rem is reduced when a chunk is pushed, so in StPop it already holds the bytes left
  // after the current chunk.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st        <= StIdle;
      step      <= '0;
      chunk     <= '0;
      rem       <= '0;
      addr_q    <= '0;
      op        <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      unique case (st)
        StIdle: begin
          if (start) begin
            addr_q <= flash_addr;
            rem    <= len;
            busy   <= 1'b1;
            step   <= '0;
            if (len == '0) begin
              st <= StFin;
            end else begin
              st <= StCfg;
              op <= bus_wr(SPI_DFR, {24'd0, dfv});
            end
          end
        end
        StCfg: begin
          step <= step + 4'd1;
          if (step == 4'd0) begin
            op <= bus_wr(SPI_CR, '0);
          end else if (step == 4'd1) begin
            op <= bus_wr(SPI_CS_V, CsSel);
          end else begin
            st   <= StCmd;
            step <= '0;
            op   <= bus_wr(SPI_DR, 32'(FLASH_CMD_READ));
          end
        end
        StCmd: begin
          step <= step + 4'd1;
          case (step)
            4'd0:    op <= bus_wr(SPI_DR, {24'd0, addr_q[23:16]});
            4'd1:    op <= bus_wr(SPI_DR, {24'd0, addr_q[15:8]});
            4'd2:    op <= bus_wr(SPI_DR, {24'd0, addr_q[7:0]});
            default: begin
              st   <= StWcmd;
              step <= '0;
              op   <= bus_rd(SPI_SR, 1'b0);
            end
          endcase
        end
        StWcmd: begin
          if (sr.tx_fifo_emp) begin
            st   <= StDcmd;
            step <= '0;
            op   <= bus_rd(SPI_DR, 1'b1);
          end
        end
        StDcmd: begin
          // Drain the four bytes clocked in while the command was shifted out.
          step <= step + 4'd1;
          if (step == 4'd3) begin
            st    <= StPush;
            step  <= '0;
            chunk <= rem_chunk;
            op    <= bus_wr(SPI_DR, '0);
          end
        end
        StPush: begin
          step <= step + 4'd1;
          if (step == chunk - 4'd1) begin
            st   <= StWdat;
            step <= '0;
            rem  <= rem - len_w'(chunk);
            op   <= bus_rd(SPI_SR, 1'b0);
          end
        end
        StWdat: begin
          if (sr.tx_fifo_emp) begin
            st        <= StPop;
            step      <= '0;
            op        <= bus_rd(SPI_DR, 1'b0);
            out_valid <= 1'b1;
          end
        end
        StPop: begin
          if (out_ready) begin
            step <= step + 4'd1;
            if (step == chunk - 4'd1) begin
              out_valid <= 1'b0;
              step      <= '0;
              if (rem != '0) begin
                st    <= StPush;
                chunk <= rem_chunk;
                op    <= bus_wr(SPI_DR, '0);
              end else begin
                st <= StCsoff;
                op <= bus_wr(SPI_CS_V, CsAll);
              end
            end
          end
        end
        StCsoff: begin
          // Enter the done cycle of StFin directly so done lands two cycles after the last pop.
          st   <= StFin;
          step <= 4'd1;
          done <= 1'b1;
          op   <= '0;
        end
        StFin: begin
          if (step == 4'd0) begin
            step <= 4'd1;
            done <= 1'b1;
          end else begin
            st   <= StIdle;
            step <= '0;
            done <= 1'b0;
            busy <= 1'b0;
          end
        end
        default: st <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_flash_rd.sv
// Bench for spi_flash_rd: behavioural spi block + 25-series flash model on the bus,
// scoreboard of expected stream bytes, table of transfers and a few hand sequences.
module tb_spi_flash_rd;
  import spi_flash_rd_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [23:0] flash_addr = '0;
  logic [15:0] len = '0;
  logic [7:0]  dfv = '0;
  logic        busy, done, out_valid;
  logic        out_ready = 1'b1;
  logic [7:0]  out_data;

  spi_flash_rd_if bus ();

  spi_flash_rd #(.cs_w(8), .cs_idx(0), .len_w(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .flash_addr (flash_addr),
    .len        (len),
    .dfv        (dfv),
    .busy       (busy),
    .done       (done),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] mem_byte(input logic [23:0] a);
    return a[7:0] + 8'hA0 + (a[15:8] - 8'd1) + a[23:16] * 8'd7;
  endfunction

  typedef struct packed {
    logic [4:0]  a;
    logic [31:0] d;
  } wr_t;

  // spi block + flash model state
  logic [7:0]  tx_q[$];
  logic [7:0]  rx_q[$];
  int          shift_cnt = 0;
  logic [7:0]  shift_rx = '0;
  logic [7:0]  txb = '0;
  logic [7:0]  cs_v_m = 8'hFF;
  logic [7:0]  dfr_m = '0;
  int          fl_n = 0;
  logic [7:0]  fl_cmd = '0;
  logic [23:0] fl_addr = '0;
  int          rx_cnt = 0;
  int          tx_cnt = 0;
  logic [7:0]  rx_head = '0;

  // monitor state
  wr_t        wlog[$];
  logic [7:0] exp_q[$];
  int cyc = 0, start_cyc = 0, done_cyc = 0, last_pop_cyc = 0, done_cnt = 0, got_cnt = 0;
  int we_cnt = 0, re_cnt = 0, rx_max = 0, model_err = 0, stall_err = 0, re_err = 0;
  logic       prev_stall = 1'b0;
  logic [7:0] prev_data = '0;
  logic [7:0] first_got = '0;

  always_comb begin
    bus.spi_rd = '0;
    if (bus.spi_addr == SPI_SR) begin
      bus.spi_rd[7:0] = {3'b000, shift_cnt != 0, rx_cnt == 8, rx_cnt == 0, tx_cnt == 8,
                         (tx_cnt == 0) && (shift_cnt == 0)};
    end else if (bus.spi_addr == SPI_DR) begin
      bus.spi_rd[7:0] = rx_head;
    end
  end

  initial forever begin
    @(negedge clk);
    if (rst) begin
      tx_q.delete();
      rx_q.delete();
      shift_cnt  = 0;
      cs_v_m     = 8'hFF;
      dfr_m      = '0;
      fl_n       = 0;
      prev_stall = 1'b0;
    end else begin
      cyc++;
      // monitor: checks use values before the model reacts to this cycle's access
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (start && !busy) start_cyc = cyc;
      if (prev_stall && out_valid && out_data !== prev_data) stall_err++;
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      if (out_valid && bus.spi_re && !out_ready) re_err++;
      if (bus.spi_we) we_cnt++;
      if (bus.spi_re) re_cnt++;
      if (out_valid && out_ready) begin
        if (got_cnt == 0) first_got = out_data;
        if (exp_q.size() == 0) check("extra_byte", {56'd0, out_data}, 64'hxx);
        else check($sformatf("byte%0d", got_cnt), {56'd0, out_data}, {56'd0, exp_q.pop_front()});
        got_cnt++;
        last_pop_cyc = cyc;
      end
      // spi block reacts to the access
      if (bus.spi_we) begin
        wlog.push_back(wr_t'{a: bus.spi_addr, d: bus.spi_wd});
        case (bus.spi_addr)
          SPI_DFR:  dfr_m = bus.spi_wd[7:0];
          SPI_CS_V: begin
            if (cs_v_m[0] && !bus.spi_wd[0]) fl_n = 0;
            cs_v_m = bus.spi_wd[7:0];
          end
          SPI_DR:   begin
            if (tx_q.size() >= 8) model_err++;
            tx_q.push_back(bus.spi_wd[7:0]);
          end
          default: ;
        endcase
      end
      if (bus.spi_re && bus.spi_addr == SPI_DR) begin
        if (rx_q.size() == 0) model_err++;
        else void'(rx_q.pop_front());
      end
      if (shift_cnt > 0) begin
        shift_cnt--;
        if (shift_cnt == 0) begin
          if (rx_q.size() >= 8) model_err++;
          else rx_q.push_back(shift_rx);
          if (rx_q.size() > rx_max) rx_max = rx_q.size();
        end
      end else if (tx_q.size() > 0) begin
        txb = tx_q.pop_front();
        if (cs_v_m[0]) begin
          shift_rx = 8'hFF;
        end else begin
          if (fl_n == 0) begin
            fl_cmd   = txb;
            shift_rx = 8'hFF;
          end else if (fl_n < 4) begin
            fl_addr  = {fl_addr[15:0], txb};
            shift_rx = 8'hFF;
          end else begin
            shift_rx = (fl_cmd == 8'h03) ? mem_byte(fl_addr + 24'(fl_n - 4)) : 8'hFF;
          end
          fl_n++;
        end
        shift_cnt = 2 + int'(dfr_m[1:0]);
      end
    end
    tx_cnt  = tx_q.size();
    rx_cnt  = rx_q.size();
    rx_head = (rx_cnt > 0) ? rx_q[0] : 8'h00;
  end

  typedef struct {
    logic [23:0] a;
    int          n;
    logic [7:0]  d;
    bit          rnd;
    bit          restart;
    logic [7:0]  first;
  } vec_t;

  vec_t vecs[6];

  task automatic run_xfer(input vec_t v);
    int guard;
    wr_t pro[7];
    exp_q.delete();
    wlog.delete();
    done_cnt = 0; we_cnt = 0; re_cnt = 0; rx_max = 0; got_cnt = 0;
    model_err = 0; stall_err = 0; re_err = 0;
    for (int i = 0; i < v.n; i++) exp_q.push_back(mem_byte(v.a + 24'(i)));
    @(posedge clk); #1;
    flash_addr = v.a; len = 16'(v.n); dfv = v.d; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    if (v.restart) begin
      start = 1'b1; flash_addr = v.a ^ 24'h5a5a5a; len = 16'(v.n + 3);
      @(posedge clk); #1;
      start = 1'b0;
    end
    guard = 0;
    while (done_cnt == 0 && guard < 20000) begin
      @(posedge clk); #1;
      if (v.rnd) out_ready = 1'($urandom_range(0, 1));
      guard++;
    end
    out_ready = 1'b1;
    check($sformatf("done_seen_n%0d", v.n), {63'd0, done_cnt != 0}, 64'd1);
    repeat (4) @(posedge clk);
    #1;
    check("done_pulses", 64'(done_cnt), 64'd1);
    check("bytes_out", 64'(got_cnt), 64'(v.n));
    check("sb_left", 64'(exp_q.size()), 64'd0);
    check("busy_end", {63'd0, busy}, 64'd0);
    if (v.n == 0) begin
      check("no_access", 64'(we_cnt + re_cnt), 64'd0);
      check("done_lat_len0", 64'(done_cyc - start_cyc), 64'd2);
    end else begin
      pro[0] = '{a: SPI_DFR, d: {24'd0, v.d}};
      pro[1] = '{a: SPI_CR, d: 32'd0};
      pro[2] = '{a: SPI_CS_V, d: 32'h0000_00FE};
      pro[3] = '{a: SPI_DR, d: 32'h0000_0003};
      pro[4] = '{a: SPI_DR, d: {24'd0, v.a[23:16]}};
      pro[5] = '{a: SPI_DR, d: {24'd0, v.a[15:8]}};
      pro[6] = '{a: SPI_DR, d: {24'd0, v.a[7:0]}};
      check("wr_count", 64'(wlog.size()), 64'(v.n + 8));
      for (int k = 0; k < 7; k++)
        check($sformatf("prologue%0d", k), (k < wlog.size()) ? 64'(wlog[k]) : '1, 64'(pro[k]));
      check("cs_release", (wlog.size() > 0) ? 64'(wlog[wlog.size() - 1]) : '1,
            64'(wr_t'{a: SPI_CS_V, d: 32'h0000_00FF}));
      check("first_byte", {56'd0, first_got}, {56'd0, v.first});
      check("rx_max", 64'(rx_max), 64'((v.n > 8) ? 8 : v.n));
      check("model_err", 64'(model_err), 64'd0);
      check("stall_stable", 64'(stall_err), 64'd0);
      check("re_needs_ready", 64'(re_err), 64'd0);
      check("done_after_pop", 64'(done_cyc - last_pop_cyc), 64'd2);
    end
  endtask

  initial begin
    int guard;
    vecs[0] = '{a: 24'h000100, n: 4,  d: 8'd2, rnd: 1'b0, restart: 1'b0, first: 8'hA0};
    vecs[1] = '{a: 24'h000200, n: 9,  d: 8'd0, rnd: 1'b0, restart: 1'b0, first: 8'hA1};
    vecs[2] = '{a: 24'h0130F0, n: 5,  d: 8'd1, rnd: 1'b1, restart: 1'b0, first: 8'hC6};
    vecs[3] = '{a: 24'h000108, n: 8,  d: 8'd3, rnd: 1'b0, restart: 1'b1, first: 8'hA8};
    vecs[4] = '{a: 24'h000000, n: 0,  d: 8'd2, rnd: 1'b0, restart: 1'b0, first: 8'h00};
    vecs[5] = '{a: 24'hFFFFFE, n: 20, d: 8'd0, rnd: 1'b1, restart: 1'b0, first: 8'h95};

    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_done", {63'd0, done}, 64'd0);
    check("rst_valid", {63'd0, out_valid}, 64'd0);
    check("rst_we_re", {62'd0, bus.spi_we, bus.spi_re}, 64'd0);
    check("rst_addr_wd", {27'd0, bus.spi_addr, bus.spi_wd}, 64'd0);
    rst = 1'b0;

    // len=0, then a start landing on the done cycle must be ignored
    done_cnt = 0;
    @(posedge clk); #1;
    flash_addr = 24'h000100; len = 16'd0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("len0_busy", {63'd0, busy}, 64'd1);
    @(posedge clk); #1;
    check("len0_done_at_2", {63'd0, done}, 64'd1);
    start = 1'b1; len = 16'd4;
    @(posedge clk); #1;
    start = 1'b0;
    check("start_on_done_busy", {63'd0, busy}, 64'd0);
    repeat (6) @(posedge clk);
    #1;
    check("start_on_done_pulses", 64'(done_cnt), 64'd1);
    check("start_on_done_idle", {62'd0, busy, bus.spi_we}, 64'd0);

    // reset while stalled in the pop phase
    exp_q.delete();
    out_ready = 1'b0;
    @(posedge clk); #1;
    flash_addr = 24'h000100; len = 16'd4; dfv = 8'd0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    guard = 0;
    while (!out_valid && guard < 500) begin
      @(posedge clk); #1;
      guard++;
    end
    check("pop_reached", {63'd0, out_valid}, 64'd1);
    repeat (2) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("mid_rst_valid", {63'd0, out_valid}, 64'd0);
    check("mid_rst_busy", {63'd0, busy}, 64'd0);
    check("mid_rst_we_re", {62'd0, bus.spi_we, bus.spi_re}, 64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    out_ready = 1'b1;

    foreach (vecs[i]) run_xfer(vecs[i]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
